// File: rtl/rv32i_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the RV32I register file's single write port.
// Optional round-robin arbitration when WB_RR_ARB_EN is defined; fixed priority (lowest index) otherwise.
module rv32i_wb_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*5-1:0]    req_rd,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic                    flush,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;

    logic             rf_we_reg,    rf_we_next;
    logic [4:0]       rf_waddr_reg, rf_waddr_next;
    logic [31:0]      rf_wdata_reg, rf_wdata_next;
    logic [31:0]      busy_reg,     busy_next;

`ifdef WB_RR_ARB_EN
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    int               cand;

    // Search begins one past the last winner so every valid requester is reached within NUM_REQ grants.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr_reg) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= PTR_W'(NUM_REQ - 1);
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(k);
            end
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_any && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_rd   = req_rd[5*i +: 5];
                sel_data = req_data[32*i +: 32];
            end
        end
    end

    // A granted x0 write is consumed but never reaches the register file or scoreboard.
    always_comb begin
        rf_we_next    = grant_any && (sel_rd != 5'd0);
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;
        if (grant_any) begin
            rf_waddr_next = sel_rd;
            rf_wdata_next = sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= 5'd0;
            rf_wdata_reg <= 32'd0;
        end else begin
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
        end
    end

    // Flush beats issue beats commit; an issue to the committing register keeps it busy.
    assign busy_next[0] = 1'b0;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            assign busy_next[gi] = flush                                    ? 1'b0 :
                                   (issue_valid && issue_rd == 5'(gi))      ? 1'b1 :
                                   (rf_we_reg && rf_waddr_reg == 5'(gi))    ? 1'b0 :
                                                                              busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign rf_we    = rf_we_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;
    assign rs1_busy = busy_reg[rs1] && (rs1 != 5'd0);
    assign rs2_busy = busy_reg[rs2] && (rs2 != 5'd0);

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Directed testbench for rv32i_wb_arbiter (NUM_REQ=2); contention expectations follow WB_RR_ARB_EN.
module tb_rv32i_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_rd;
    logic [63:0] req_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;

    int checks   = 0;
    int failures = 0;

    rv32i_wb_arbiter #(.NUM_REQ(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  exp_ready [4];
    logic [4:0]  exp_rd    [4];
    logic [31:0] exp_data  [4];

    initial begin
        rst_n       = 1'b0;
        req_valid   = 2'b11;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        flush       = 1'b0;
        rs1         = 5'd0;
        rs2         = 5'd0;

        // 1: reset state
        tick();
        tick();
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r);
            rs2 = 5'(31 - r);
            #1;
            chk($sformatf("reset_busy_r%0d", r), {30'd0, rs1_busy, rs2_busy}, 32'd0);
        end
        rst_n     = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("idle_ready", 32'(req_ready), 32'd0);
        tick();
        chk("idle_rf_we", 32'(rf_we), 32'd0);

        // 2: single grant from requester 0
        req_valid     = 2'b01;
        req_rd[4:0]   = 5'd5;
        req_data[31:0] = 32'hDEADBEEF;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("single_rf_we", 32'(rf_we), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        chk("single_after_we", 32'(rf_we), 32'd0);

        // 4: x0 request from requester 1 is granted but produces no write
        req_valid       = 2'b10;
        req_rd[9:5]     = 5'd0;
        req_data[63:32] = 32'h12345678;
        #1;
        chk("x0_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        rs1 = 5'd0;
        #1;
        chk("x0_rf_we", 32'(rf_we), 32'd0);
        chk("x0_busy0", 32'(rs1_busy), 32'd0);
        tick();

        // 3: contention, both held valid for four cycles
        req_rd          = {5'd4, 5'd3};
        req_data        = {32'hBBBB0001, 32'hAAAA0000};
`ifdef WB_RR_ARB_EN
        exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_rd    = '{5'd3, 5'd4, 5'd3, 5'd4};
        exp_data  = '{32'hAAAA0000, 32'hBBBB0001, 32'hAAAA0000, 32'hBBBB0001};
`else
        exp_ready = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_rd    = '{5'd3, 5'd3, 5'd3, 5'd3};
        exp_data  = '{32'hAAAA0000, 32'hAAAA0000, 32'hAAAA0000, 32'hAAAA0000};
`endif
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("cont_ready_c%0d", c), 32'(req_ready), 32'(exp_ready[c]));
            tick();
            chk($sformatf("cont_we_c%0d", c), 32'(rf_we), 32'd1);
            chk($sformatf("cont_waddr_c%0d", c), 32'(rf_waddr), 32'(exp_rd[c]));
            chk($sformatf("cont_wdata_c%0d", c), rf_wdata, exp_data[c]);
        end
        req_valid = 2'b00;
        tick();
        chk("cont_after_we", 32'(rf_we), 32'd0);

        // 5: scoreboard set, commit clear, and set winning over commit
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd7;
        #1;
        chk("sb_issue_busy", 32'(rs1_busy), 32'd1);
        req_valid      = 2'b01;
        req_rd[4:0]    = 5'd7;
        req_data[31:0] = 32'h00000777;
        tick();
        req_valid = 2'b00;
        #1;
        chk("sb_commit_we", 32'(rf_we), 32'd1);
        chk("sb_commit_busy", 32'(rs1_busy), 32'd1);
        tick();
        chk("sb_cleared", 32'(rs1_busy), 32'd0);

        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        req_valid   = 2'b01;
        tick();
        req_valid   = 2'b00;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        chk("sb_race_we", 32'(rf_we), 32'd1);
        tick();
        issue_valid = 1'b0;
        rs2 = 5'd7;
        #1;
        chk("sb_race_rs1", 32'(rs1_busy), 32'd1);
        chk("sb_race_rs2", 32'(rs2_busy), 32'd1);

        // 6: flush clears everything, pending write still commits
        issue_valid = 1'b1;
        issue_rd    = 5'd2;
        tick();
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd2;
        rs2 = 5'd9;
        #1;
        chk("fl_pre_busy", {30'd0, rs1_busy, rs2_busy}, 32'd3);
        req_valid      = 2'b01;
        req_rd[4:0]    = 5'd20;
        req_data[31:0] = 32'hC0FFEE00;
        tick();
        req_valid   = 2'b00;
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        #1;
        chk("fl_pending_we", 32'(rf_we), 32'd1);
        chk("fl_pending_waddr", 32'(rf_waddr), 32'd20);
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("fl_busy_2_9", {30'd0, rs1_busy, rs2_busy}, 32'd0);
        rs1 = 5'd12;
        rs2 = 5'd7;
        #1;
        chk("fl_busy_12_7", {30'd0, rs1_busy, rs2_busy}, 32'd0);

        // reset asserted while a write is in flight
        req_valid      = 2'b01;
        req_rd[4:0]    = 5'd6;
        req_data[31:0] = 32'h66666666;
        issue_valid    = 1'b1;
        issue_rd       = 5'd11;
        tick();
        req_valid   = 2'b00;
        issue_valid = 1'b0;
        rs1 = 5'd11;
        #1;
        chk("rst_pre_we", 32'(rf_we), 32'd1);
        chk("rst_pre_busy", 32'(rs1_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_we", 32'(rf_we), 32'd0);
        chk("rst_async_busy", 32'(rs1_busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_release_we", 32'(rf_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
